pes_crc16_sched: RTL

Round-robin scheduler that shares one `pes_crc16_parallel` byte-wide CRC16 engine between `NREQ` packet requesters. It sequences the engine's `load` → byte stream → `d_finish` protocol for one packet at a time and captures the two result bytes from the engine's 8-bit `crc_out`. It returns a tagged 16-bit CRC through a valid/ready result port. It sits between the packet sources and the single CRC engine instance.

---
 rtl/pes_crc16_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pes_crc16_sched.sv
// pes_crc16_sched: round-robin scheduler sharing one byte-wide CRC16 engine; define PES_CRC16_SCHED_MAXLEN_EN to abort packets longer than MAXLEN
module pes_crc16_sched #(
    parameter int NREQ   = 4,
    parameter int MAXLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              eng_load,
    output logic              eng_d_finish,
    output logic [7:0]        eng_crc_in,
    input  logic [7:0]        eng_crc_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_crc,
    output logic [2:0]        res_id,
    output logic              err,
    output logic [2:0]        err_id
);
    localparam int IW = $clog2(NREQ);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_FIN    = 3'd3;
    localparam logic [2:0] S_CAP_HI = 3'd4;
    localparam logic [2:0] S_CAP_LO = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ABORT  = 3'd7;

    if (NREQ < 2 || NREQ > 8 || MAXLEN < 1) begin : g_bad_cfg
        $error("pes_crc16_sched: NREQ must be 2..8 and MAXLEN positive");
    end

    logic [2:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, g_q, g_d, pick, hi_idx, lo_idx, g_next;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [15:0]     crc_q, crc_d;
    logic            hi_any, lo_any, in_data, g_valid, g_last, over, release_g;

    assign in_data   = state_q == S_DATA;
    assign g_valid   = req_valid[g_q];
    assign g_last    = req_last[g_q];
    assign g_next    = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
    assign req_ready = (in_data && !over) ? grant_q : '0;
    assign grant     = grant_q;
    assign eng_load     = state_q == S_INIT;
    assign eng_d_finish = state_q == S_FIN;
    assign eng_crc_in   = in_data ? req_data[{g_q, 3'b000} +: 8] : 8'h00;
    assign res_valid = state_q == S_DONE;
    assign res_crc   = crc_q;
    assign res_id    = res_valid ? 3'(g_q) : 3'd0;
    assign err       = state_q == S_ABORT;
    assign err_id    = err ? 3'(g_q) : 3'd0;
    assign release_g = err || (res_valid && res_ready);

`ifdef PES_CRC16_SCHED_MAXLEN_EN
    localparam int CW = $clog2(MAXLEN + 2);
    logic [CW-1:0] cnt_q;
    // once MAXLEN bytes are in, any further byte of the packet is refused and the packet aborts
    assign over = in_data && cnt_q == CW'(MAXLEN);
    // bytes accepted in the current packet, saturating at MAXLEN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else if (state_q == S_INIT) cnt_q <= '0;
        else if (in_data && g_valid && !over) cnt_q <= cnt_q + CW'(1);
    end
`else
    assign over = 1'b0;
`endif

    // first requester at or after ptr, wrapping; the descending scan leaves the lowest match
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_any = 1'b1;
                lo_idx = IW'(i);
                if (IW'(i) >= ptr_q) begin
                    hi_any = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
        pick = hi_any ? hi_idx : lo_idx;
    end

    // engine sequencing: load, stream bytes, finish, capture both CRC bytes, hand off result
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        grant_d = grant_q;
        crc_d   = crc_q;
        case (state_q)
            S_IDLE: if (lo_any) begin
                state_d = S_INIT;
                g_d = pick;
                grant_d = '0;
                grant_d[pick] = 1'b1;
            end
            S_INIT:   state_d = S_DATA;
            S_DATA:   state_d = (!g_valid || over) ? S_ABORT : (g_last ? S_FIN : S_DATA);
            S_FIN:    state_d = S_CAP_HI;
            S_CAP_HI: begin
                crc_d[15:8] = eng_crc_out;
                state_d = S_CAP_LO;
            end
            S_CAP_LO: begin
                crc_d[7:0] = eng_crc_out;
                state_d = S_DONE;
            end
            default: if (release_g) begin
                state_d = S_IDLE;
                ptr_d = g_next;
                grant_d = '0;
            end
        endcase
    end

    // state registers; reset drops any packet in flight without a result or error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            grant_q <= '0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            grant_q <= grant_d;
            crc_q   <= crc_d;
        end
    end
endmodule
